// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: N-bit ALU with registered result and flags, start/done
// handshake, shifts, and an iterative shift-and-add multiplier.
module alu_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Binvert,
    input  logic [2:0]       Operation,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             COUT,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW:0]     cnt;

    logic [WIDTH-1:0] mb;
    logic [WIDTH:0]   add_full;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic [WIDTH-1:0] acc_next;

    assign mb       = Binvert ? ~B : B;
    assign add_full = {1'b0, A} + {1'b0, mb} + {{WIDTH{1'b0}}, Binvert};
    assign add_ovf  = (A[WIDTH-1] == mb[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (Operation)
            OP_AND: alu_res = A & mb;
            OP_OR:  alu_res = A | mb;
            OP_XOR: alu_res = A ^ mb;
            OP_ADD: begin
                alu_res  = add_full[WIDTH-1:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = add_ovf;
            end
            // Sign of the true difference is the sum sign corrected by overflow.
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, add_full[WIDTH-1] ^ add_ovf};
                alu_cout = add_full[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SLL:  alu_res = A << B[SHW-1:0];
            OP_SRL:  alu_res = A >> B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            Result   <= '0;
            Zero     <= 1'b1;
            COUT     <= 1'b0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Operation == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= A;
                            mplier <= B;
                            cnt    <= (SHW+1)'(WIDTH);
                            Busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            Result   <= alu_res;
                            Zero     <= (alu_res == '0);
                            COUT     <= alu_cout;
                            Overflow <= alu_ovf;
                            Done     <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - (SHW+1)'(1);
                    // Last iteration commits the accumulator straight to Result.
                    if (cnt == (SHW+1)'(1)) begin
                        Result   <= acc_next;
                        Zero     <= (acc_next == '0);
                        COUT     <= 1'b0;
                        Overflow <= 1'b0;
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: directed and randomized checks of alu_nbit_seq against an
// arithmetic reference model.
module tb_alu_nbit_seq;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             Clock = 1'b0;
    logic             ResetN;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Binvert;
    logic [2:0]       Operation;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             COUT;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;

    logic [2:0]       b2bOps [3] = '{3'd0, 3'd1, 3'd3};
    logic [WIDTH-1:0] ra, rb, er;
    logic [2:0]       rop;
    logic             rbin, ec, ev;
    int               doneSeen;

    alu_nbit_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .A(A), .B(B),
        .Binvert(Binvert), .Operation(Operation), .Result(Result), .Zero(Zero),
        .COUT(COUT), .Overflow(Overflow), .Busy(Busy), .Done(Done)
    );

    initial forever #5 Clock = ~Clock;

    // Reference model: exact integer arithmetic, then reduced to WIDTH bits.
    function automatic void refModel(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic binv,
                                     output logic [WIDTH-1:0] r, output logic c,
                                     output logic v);
        logic [WIDTH-1:0] mbv;
        longint u, s, amtScale;
        mbv = binv ? ~b : b;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        amtScale = longint'(1) << b[SHW-1:0];
        case (op)
            3'd0: r = a & mbv;
            3'd1: r = a | mbv;
            3'd3: r = a ^ mbv;
            3'd2, 3'd4: begin
                u = longint'(a) + longint'(mbv) + longint'(binv);
                s = longint'($signed(a)) + longint'($signed(mbv)) + longint'(binv);
                c = u[WIDTH];
                v = (s > ((longint'(1) << (WIDTH-1)) - 1)) || (s < -(longint'(1) << (WIDTH-1)));
                if (op == 3'd2) r = u[WIDTH-1:0];
                else            r = (s < 0) ? WIDTH'(1) : '0;
            end
            3'd5: begin
                u = longint'(a) * amtScale;
                r = u[WIDTH-1:0];
            end
            3'd6: begin
                u = longint'(a) / amtScale;
                r = u[WIDTH-1:0];
            end
            default: begin
                u = longint'(a) * longint'(b);
                r = u[WIDTH-1:0];
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic binv);
        Start     = 1'b1;
        Operation = op;
        A         = a;
        B         = b;
        Binvert   = binv;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic runSingle(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic binv);
        logic [WIDTH-1:0] r;
        logic c, v;
        refModel(op, a, b, binv, r, c, v);
        applyStimulus(op, a, b, binv);
        checkOutput({tag, " done"}, Done, 1);
        checkOutput({tag, " busy"}, Busy, 0);
        checkOutput({tag, " result"}, Result, r);
        checkOutput({tag, " zero"}, Zero, (r == '0));
        checkOutput({tag, " cout"}, COUT, c);
        checkOutput({tag, " ovf"}, Overflow, v);
        @(negedge Clock);
        checkOutput({tag, " done drop"}, Done, 0);
        checkOutput({tag, " result hold"}, Result, r);
    endtask

    task automatic runMul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic c, v;
        int n;
        refModel(3'd7, a, b, 1'b0, r, c, v);
        applyStimulus(3'd7, a, b, 1'($urandom));
        n = 1;
        while (Done !== 1'b1 && n < 3 * WIDTH) begin
            checkOutput({tag, " busy"}, Busy, 1);
            Start     = (n == 3 || n == 6);
            A         = WIDTH'($urandom);
            B         = WIDTH'($urandom);
            Operation = 3'($urandom);
            Binvert   = 1'($urandom);
            @(negedge Clock);
            n++;
        end
        Start = 1'b0;
        checkOutput({tag, " latency"}, n, WIDTH + 1);
        checkOutput({tag, " result"}, Result, r);
        checkOutput({tag, " zero"}, Zero, (r == '0));
        checkOutput({tag, " cout"}, COUT, 0);
        checkOutput({tag, " ovf"}, Overflow, 0);
        checkOutput({tag, " busy end"}, Busy, 0);
        @(negedge Clock);
        checkOutput({tag, " done drop"}, Done, 0);
        checkOutput({tag, " no queued start"}, Busy, 0);
    endtask

    initial begin
        ResetN    = 1'b0;
        Start     = 1'b0;
        A         = '0;
        B         = '0;
        Binvert   = 1'b0;
        Operation = 3'd0;
        #12 ResetN = 1'b1;
        @(negedge Clock);
        checkOutput("reset result", Result, 0);
        checkOutput("reset zero", Zero, 1);
        checkOutput("reset busy", Busy, 0);
        checkOutput("reset done", Done, 0);

        runSingle("add ovf", 3'd2, 16'h7FFF, 16'h0001, 1'b0);
        runSingle("sub eq", 3'd2, 16'h0005, 16'h0005, 1'b1);
        runSingle("slt neg", 3'd4, 16'hFFFE, 16'h0003, 1'b1);
        runSingle("slt swap", 3'd4, 16'h0003, 16'hFFFE, 1'b1);
        runSingle("sll max", 3'd5, 16'h0001, 16'h000F, 1'b0);
        runSingle("srl binv", 3'd6, 16'h8000, 16'h0004, 1'b1);

        // Asynchronous reset between edges while Done is high.
        applyStimulus(3'd1, 16'h00F0, 16'h0000, 1'b0);
        #2 ResetN = 1'b0;
        #1;
        checkOutput("async result", Result, 0);
        checkOutput("async zero", Zero, 1);
        checkOutput("async done", Done, 0);
        checkOutput("async busy", Busy, 0);
        @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);

        runMul("mul directed", 16'h00FF, 16'h0102);
        checkOutput("mul directed const", Result, 16'h00FE);

        A       = 16'hF0F0;
        B       = 16'h0FF0;
        Binvert = 1'b0;
        Start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Operation = b2bOps[i];
            @(negedge Clock);
            refModel(b2bOps[i], 16'hF0F0, 16'h0FF0, 1'b0, er, ec, ev);
            checkOutput("b2b done", Done, 1);
            checkOutput("b2b result", Result, er);
        end
        Start = 1'b0;
        @(negedge Clock);
        checkOutput("b2b done drop", Done, 0);

        // Reset partway through a multiply must abort it silently.
        applyStimulus(3'd7, 16'h1234, 16'h0FF1, 1'b0);
        repeat (7) @(negedge Clock);
        #2 ResetN = 1'b0;
        #1;
        checkOutput("midmul busy", Busy, 0);
        checkOutput("midmul result", Result, 0);
        checkOutput("midmul done", Done, 0);
        @(negedge Clock);
        ResetN   = 1'b1;
        doneSeen = 0;
        repeat (WIDTH + 4) begin
            @(negedge Clock);
            if (Done !== 1'b0 || Busy !== 1'b0) doneSeen++;
        end
        checkOutput("midmul no done", doneSeen, 0);
        runMul("mul after reset", 16'h1234, 16'h0FF1);

        repeat (40) begin
            rop  = 3'($urandom_range(6, 0));
            ra   = WIDTH'($urandom);
            rb   = ($urandom_range(7, 0) == 0) ? ra : WIDTH'($urandom);
            rbin = 1'($urandom);
            runSingle("rand op", rop, ra, rb, rbin);
        end
        repeat (4) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            runMul("rand mul", ra, rb);
        end
        runMul("mul zero", 16'h0000, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
